// File: rtl/rdx2_butterfly.sv
`default_nettype none
// ============================================================================
// Module   : rdx2_butterfly
// Brief    : Pipelined radix-2 DIT butterfly, X = A + B*W, Y = A - B*W, with
//            rounding, optional halving, saturation and sticky overflow.
// Revision : 1.0
// ============================================================================
module rdx2_butterfly #(
   parameter int B_DATA = 18,
   parameter int B_TWD  = 18
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     clock_en_i,
   input  logic                     in_valid_i,
   input  logic                     scale_i,
   input  logic signed [B_DATA-1:0] a_re_i,
   input  logic signed [B_DATA-1:0] a_im_i,
   input  logic signed [B_DATA-1:0] b_re_i,
   input  logic signed [B_DATA-1:0] b_im_i,
   input  logic signed [B_TWD-1:0]  w_re_i,
   input  logic signed [B_TWD-1:0]  w_im_i,
   input  logic                     clr_ovf_i,
   output logic                     out_valid_o,
   output logic signed [B_DATA-1:0] x_re_o,
   output logic signed [B_DATA-1:0] x_im_o,
   output logic signed [B_DATA-1:0] y_re_o,
   output logic signed [B_DATA-1:0] y_im_o,
   output logic                     overflow_o
);
   localparam int PW = B_DATA + B_TWD;
   localparam int SW = PW + 1;
   localparam int TW = B_DATA + 2;
   localparam int AW = B_DATA + 3;
   localparam int DW = 4 * B_DATA + 2;
   localparam logic signed [SW-1:0] RND     = SW'(2 ** (B_TWD - 3));
   localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (B_DATA - 1) - 1);
   localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

   // Returns {clipped, saturated result} of a +/- t with optional rounded halving.
   function automatic logic [B_DATA:0] add_sat(
      input logic signed [B_DATA-1:0] a,
      input logic signed [TW-1:0]     t,
      input logic                     sub,
      input logic                     half
   );
      logic signed [AW-1:0] s;
      logic                 clip;
      s = sub ? (AW'(a) - AW'(t)) : (AW'(a) + AW'(t));
      if (half) s = (s + AW'(1)) >>> 1;
      clip = 1'b0;
      if (s > SAT_MAX) begin
         s    = SAT_MAX;
         clip = 1'b1;
      end else if (s < SAT_MIN) begin
         s    = SAT_MIN;
         clip = 1'b1;
      end
      return {clip, s[B_DATA-1:0]};
   endfunction

   logic [DW-1:0]            dl_d;
   logic [DW-1:0]            dl_q [3];
   logic                     w_dvalid, w_dscale;
   logic signed [B_DATA-1:0] w_dare, w_daim, w_dbre, w_dbim;

   logic signed [PW-1:0]     mul_rr_q, mul_ii_q, mul_ri_q, mul_ir_q;
   logic signed [B_DATA-1:0] mul_are_q, mul_aim_q;
   logic                     mul_scale_q, mul_valid_q;

   logic signed [SW-1:0]     w_pr, w_pi;
   logic                     w_unused;
   logic signed [TW-1:0]     t_re_d, t_im_d, rnd_tre_q, rnd_tim_q;
   logic signed [B_DATA-1:0] rnd_are_q, rnd_aim_q;
   logic                     rnd_scale_q, rnd_valid_q;

   logic [B_DATA:0]          w_xr, w_xi, w_yr, w_yi;
   logic                     w_clip;
   logic signed [B_DATA-1:0] x_re_d, x_im_d, y_re_d, y_im_d;
   logic signed [B_DATA-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
   logic                     out_valid_q;
   logic                     ovf_d, ovf_q;

   assign dl_d = {in_valid_i, scale_i, a_re_i, a_im_i, b_re_i, b_im_i};
   assign {w_dvalid, w_dscale, w_dare, w_daim, w_dbre, w_dbim} = dl_q[2];

   // Single rounding step: half-LSB bias, then drop the twiddle fraction bits.
   always_comb begin
      w_pr   = (SW'(mul_rr_q) - SW'(mul_ii_q) + RND) >>> (B_TWD - 2);
      w_pi   = (SW'(mul_ri_q) + SW'(mul_ir_q) + RND) >>> (B_TWD - 2);
      t_re_d = w_pr[TW-1:0];
      t_im_d = w_pi[TW-1:0];
   end
   assign w_unused = &{1'b0, w_pr[SW-1:TW], w_pi[SW-1:TW]};

   always_comb begin
      w_xr   = add_sat(rnd_are_q, rnd_tre_q, 1'b0, rnd_scale_q);
      w_xi   = add_sat(rnd_aim_q, rnd_tim_q, 1'b0, rnd_scale_q);
      w_yr   = add_sat(rnd_are_q, rnd_tre_q, 1'b1, rnd_scale_q);
      w_yi   = add_sat(rnd_aim_q, rnd_tim_q, 1'b1, rnd_scale_q);
      x_re_d = w_xr[B_DATA-1:0];
      x_im_d = w_xi[B_DATA-1:0];
      y_re_d = w_yr[B_DATA-1:0];
      y_im_d = w_yi[B_DATA-1:0];
      w_clip = rnd_valid_q & (w_xr[B_DATA] | w_xi[B_DATA] | w_yr[B_DATA] | w_yi[B_DATA]);
   end

   // Clearing wins over a same-edge overflow and ignores the clock enable.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_ovf_i)
         ovf_d = 1'b0;
      else if (clock_en_i && w_clip)
         ovf_d = 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < 3; i++) dl_q[i] <= '0;
         mul_rr_q    <= '0;
         mul_ii_q    <= '0;
         mul_ri_q    <= '0;
         mul_ir_q    <= '0;
         mul_are_q   <= '0;
         mul_aim_q   <= '0;
         mul_scale_q <= 1'b0;
         mul_valid_q <= 1'b0;
         rnd_tre_q   <= '0;
         rnd_tim_q   <= '0;
         rnd_are_q   <= '0;
         rnd_aim_q   <= '0;
         rnd_scale_q <= 1'b0;
         rnd_valid_q <= 1'b0;
         x_re_q      <= '0;
         x_im_q      <= '0;
         y_re_q      <= '0;
         y_im_q      <= '0;
         out_valid_q <= 1'b0;
      end else if (clock_en_i) begin
         dl_q[0]     <= dl_d;
         dl_q[1]     <= dl_q[0];
         dl_q[2]     <= dl_q[1];
         mul_rr_q    <= PW'(w_dbre) * PW'(w_re_i);
         mul_ii_q    <= PW'(w_dbim) * PW'(w_im_i);
         mul_ri_q    <= PW'(w_dbre) * PW'(w_im_i);
         mul_ir_q    <= PW'(w_dbim) * PW'(w_re_i);
         mul_are_q   <= w_dare;
         mul_aim_q   <= w_daim;
         mul_scale_q <= w_dscale;
         mul_valid_q <= w_dvalid;
         rnd_tre_q   <= t_re_d;
         rnd_tim_q   <= t_im_d;
         rnd_are_q   <= mul_are_q;
         rnd_aim_q   <= mul_aim_q;
         rnd_scale_q <= mul_scale_q;
         rnd_valid_q <= mul_valid_q;
         x_re_q      <= x_re_d;
         x_im_q      <= x_im_d;
         y_re_q      <= y_re_d;
         y_im_q      <= y_im_d;
         out_valid_q <= rnd_valid_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i)
         ovf_q <= 1'b0;
      else
         ovf_q <= ovf_d;
   end

   assign out_valid_o = out_valid_q;
   assign x_re_o      = x_re_q;
   assign x_im_o      = x_im_q;
   assign y_re_o      = y_re_q;
   assign y_im_o      = y_im_q;
   assign overflow_o  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_rdx2_butterfly.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdx2_butterfly
// Brief    : Self-checking bench for rdx2_butterfly (vector table, stall and
//            reset sequences, randomized traffic against an arithmetic model).
// Revision : 1.0
// ============================================================================
module tb_rdx2_butterfly;
   localparam int     BD   = 18;
   localparam int     BT   = 18;
   localparam longint DMAX = 64'sd131071;
   localparam longint DMIN = -64'sd131072;

   logic clk = 1'b0;
   logic rst, ce, in_valid, scale, clr_ovf;
   logic signed [BD-1:0] a_re, a_im, b_re, b_im;
   logic signed [BT-1:0] w_re, w_im;
   logic out_valid, ovf;
   logic signed [BD-1:0] x_re, x_im, y_re, y_im;

   always #5 clk = ~clk;

   rdx2_butterfly #(.B_DATA(BD), .B_TWD(BT)) dut (
      .clock_i    (clk),
      .reset_i    (rst),
      .clock_en_i (ce),
      .in_valid_i (in_valid),
      .scale_i    (scale),
      .a_re_i     (a_re),
      .a_im_i     (a_im),
      .b_re_i     (b_re),
      .b_im_i     (b_im),
      .w_re_i     (w_re),
      .w_im_i     (w_im),
      .clr_ovf_i  (clr_ovf),
      .out_valid_o(out_valid),
      .x_re_o     (x_re),
      .x_im_o     (x_im),
      .y_re_o     (y_re),
      .y_im_o     (y_im),
      .overflow_o (ovf)
   );

   typedef struct { longint are, aim, bre, bim, wre, wim; bit scale; } smp_t;
   typedef struct { bit v; longint xr, xi, yr, yi; bit clip; } res_t;
   typedef struct { smp_t s; longint xr, xi, yr, yi; bit ovf; } vec_t;

   int     n_cmp = 0;
   int     n_fail = 0;
   longint en_edges = 0;
   longint wall = 0;
   res_t   exp_at [longint];
   bit     exp_ovf = 1'b0;
   longint hw_re [3];
   longint hw_im [3];
   bit     lat_on = 1'b0;
   longint lat_tag [$];
   longint lat_exp [$];

   task automatic chk(input string name, input longint act, input longint expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   function automatic longint wrap_t(input longint v);
      longint m;
      m = v & 64'hF_FFFF;
      if (m >= 64'sd524288) m = m - 64'sd1048576;
      return m;
   endfunction

   function automatic longint lane(input longint a, input longint t, input bit sc, output bit clip);
      longint s;
      s = a + t;
      if (sc) s = (s + 64'sd1) >>> 1;
      clip = (s > DMAX) || (s < DMIN);
      if (s > DMAX) s = DMAX;
      if (s < DMIN) s = DMIN;
      return s;
   endfunction

   // Reference: complex multiply, round to the data grid, then A +/- T.
   function automatic res_t bfly(input smp_t s);
      res_t   r;
      longint pr, pi, tr, ti;
      bit     c0, c1, c2, c3;
      pr     = s.bre * s.wre - s.bim * s.wim;
      pi     = s.bre * s.wim + s.bim * s.wre;
      tr     = wrap_t((pr + 64'sd32768) >>> 16);
      ti     = wrap_t((pi + 64'sd32768) >>> 16);
      r.v    = 1'b1;
      r.xr   = lane(s.are, tr, s.scale, c0);
      r.xi   = lane(s.aim, ti, s.scale, c1);
      r.yr   = lane(s.are, -tr, s.scale, c2);
      r.yi   = lane(s.aim, -ti, s.scale, c3);
      r.clip = c0 | c1 | c2 | c3;
      return r;
   endfunction

   function automatic smp_t rnd_smp();
      smp_t s;
      s.are   = longint'($urandom_range(0, 262143)) - 64'sd131072;
      s.aim   = longint'($urandom_range(0, 262143)) - 64'sd131072;
      s.bre   = longint'($urandom_range(0, 262143)) - 64'sd131072;
      s.bim   = longint'($urandom_range(0, 262143)) - 64'sd131072;
      s.wre   = longint'($urandom_range(0, 131072)) - 64'sd65536;
      s.wim   = longint'($urandom_range(0, 131072)) - 64'sd65536;
      s.scale = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) s.are = (s.are < 0) ? DMIN : DMAX;
      if ($urandom_range(0, 5) == 0) s.bre = (s.bre < 0) ? DMIN : DMAX;
      return s;
   endfunction

   function automatic vec_t mkv(input longint are, aim, bre, bim, wre, wim, input bit sc,
                                input longint xr, xi, yr, yi, input bit ov);
      vec_t v;
      v.s.are = are; v.s.aim = aim; v.s.bre = bre; v.s.bim = bim;
      v.s.wre = wre; v.s.wim = wim; v.s.scale = sc;
      v.xr = xr; v.xi = xi; v.yr = yr; v.yi = yi; v.ovf = ov;
      return v;
   endfunction

   // One clock: drive inputs (W trails its sample by 3 enabled edges), then check.
   task automatic step(input bit r, input bit en, input bit vld, input smp_t s, input bit clr);
      res_t   e;
      longint t0, l0;
      rst     = r;
      ce      = en;
      clr_ovf = clr;
      if (en) begin
         in_valid = vld;
         scale    = vld ? s.scale : 1'b0;
         a_re     = vld ? BD'(s.are) : '0;
         a_im     = vld ? BD'(s.aim) : '0;
         b_re     = vld ? BD'(s.bre) : '0;
         b_im     = vld ? BD'(s.bim) : '0;
         w_re     = BT'(hw_re[2]);
         w_im     = BT'(hw_im[2]);
      end else begin
         in_valid = 1'($urandom);
         scale    = 1'($urandom);
         a_re     = BD'($urandom);
         a_im     = BD'($urandom);
         b_re     = BD'($urandom);
         b_im     = BD'($urandom);
         w_re     = BT'($urandom);
         w_im     = BT'($urandom);
      end
      @(posedge clk);
      #1;
      wall++;
      if (r) begin
         exp_at.delete();
      end else if (en) begin
         if (vld) begin
            exp_at[en_edges + 6] = bfly(s);
            if (lat_on) lat_tag.push_back(wall - 1);
         end
         en_edges++;
         hw_re[2] = hw_re[1]; hw_re[1] = hw_re[0]; hw_re[0] = vld ? s.wre : 64'sd0;
         hw_im[2] = hw_im[1]; hw_im[1] = hw_im[0]; hw_im[0] = vld ? s.wim : 64'sd0;
      end
      e.v = 1'b0; e.xr = 0; e.xi = 0; e.yr = 0; e.yi = 0; e.clip = 1'b0;
      if (exp_at.exists(en_edges)) e = exp_at[en_edges];
      if (r || clr)
         exp_ovf = 1'b0;
      else if (en && e.v && e.clip)
         exp_ovf = 1'b1;
      chk("out_valid", longint'(out_valid), longint'(e.v));
      chk("x_re", longint'(x_re), e.xr);
      chk("x_im", longint'(x_im), e.xi);
      chk("y_re", longint'(y_re), e.yr);
      chk("y_im", longint'(y_im), e.yi);
      chk("overflow", longint'(ovf), longint'(exp_ovf));
      if (lat_on && out_valid && lat_tag.size() > 0) begin
         t0 = lat_tag.pop_front();
         l0 = lat_exp.pop_front();
         chk("stall_latency", wall - t0, l0);
      end
   endtask

   initial begin
      vec_t vt [6];
      smp_t z;
      bit   seen;
      z.are = 0; z.aim = 0; z.bre = 0; z.bim = 0; z.wre = 0; z.wim = 0; z.scale = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hw_re[i] = 0;
         hw_im[i] = 0;
      end
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0; scale = 1'b0; clr_ovf = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;

      step(1'b1, 1'b1, 1'b0, z, 1'b0);
      step(1'b1, 1'b1, 1'b0, z, 1'b0);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_overflow", longint'(ovf), 0);

      vt[0] = mkv(100, 0, 50, 20, 65536, 0, 1'b0, 150, 20, 50, -20, 1'b0);
      vt[1] = mkv(100, 0, 50, 20, 0, -65536, 1'b0, 120, -50, 80, 50, 1'b0);
      vt[2] = mkv(0, 0, 10, 7, 0, 65536, 1'b0, -7, 10, 7, -10, 1'b0);
      vt[3] = mkv(3, -3, 0, 0, 65536, 0, 1'b1, 2, -1, 2, -1, 1'b0);
      vt[4] = mkv(131071, 0, 1, 0, 65536, 0, 1'b0, 131071, 0, 131070, 0, 1'b1);
      vt[5] = mkv(-131072, 0, -131072, 0, 65536, 0, 1'b0, -131072, 0, 0, 0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         seen = 1'b0;
         step(1'b0, 1'b1, 1'b0, z, 1'b1);
         step(1'b0, 1'b1, 1'b1, vt[i].s, 1'b0);
         for (int c = 0; c < 12 && !seen; c++) begin
            step(1'b0, 1'b1, 1'b0, z, 1'b0);
            if (out_valid) begin
               seen = 1'b1;
               chk("vec_x_re", longint'(x_re), vt[i].xr);
               chk("vec_x_im", longint'(x_im), vt[i].xi);
               chk("vec_y_re", longint'(y_re), vt[i].yr);
               chk("vec_y_im", longint'(y_im), vt[i].yi);
               chk("vec_overflow", longint'(ovf), longint'(vt[i].ovf));
            end
         end
         chk("vec_seen", longint'(seen), 1);
      end

      // Sticky overflow, then a clear while the clock enable is low.
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, z, 1'b0);
      chk("ovf_sticky", longint'(ovf), 1);
      step(1'b0, 1'b0, 1'b0, z, 1'b1);
      chk("ovf_clr_stalled", longint'(ovf), 0);

      // Clear arriving on the same edge as a clipping result wins.
      step(1'b0, 1'b1, 1'b1, vt[4].s, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, z, 1'b0);
      step(1'b0, 1'b1, 1'b0, z, 1'b1);
      chk("clr_priority_valid", longint'(out_valid), 1);
      chk("clr_priority_ovf", longint'(ovf), 0);
      step(1'b0, 1'b1, 1'b0, z, 1'b0);

      // Eight-sample stream with a 3-cycle stall before sample 4.
      lat_on = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 4)
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, z, 1'b0);
         lat_exp.push_back(i < 4 ? 64'sd9 : 64'sd6);
         step(1'b0, 1'b1, 1'b1, rnd_smp(), 1'b0);
      end
      for (int c = 0; c < 20 && lat_tag.size() > 0; c++) step(1'b0, 1'b1, 1'b0, z, 1'b0);
      chk("stall_drained", longint'(lat_tag.size()), 0);
      lat_on = 1'b0;

      // Reset with four samples in flight.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, rnd_smp(), 1'b0);
      step(1'b1, 1'b1, 1'b0, z, 1'b0);
      chk("rst_flight_valid", longint'(out_valid), 0);
      chk("rst_flight_x_re", longint'(x_re), 0);
      chk("rst_flight_y_im", longint'(y_im), 0);
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 1'b1, 1'b0, z, 1'b0);
         chk("rst_no_stale", longint'(out_valid), 0);
      end

      for (int i = 0; i < 400; i++) begin
         bit ren, rvld, rclr;
         ren  = ($urandom_range(0, 9) != 0);
         rvld = ($urandom_range(0, 3) != 0);
         rclr = ($urandom_range(0, 29) == 0);
         step(1'b0, ren, rvld, rnd_smp(), rclr);
      end
      for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, z, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
